// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
package mult_pkg;

  localparam int unsigned N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iteration counter must hold the value n itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational from req and the
// last-grant pointer; the pointer only moves when update is pulsed.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       winner_in,
  output logic [1:0] grant
);

  logic last;

  // Last-grant pointer; resetting to 1 lets client 0 win the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last <= 1'b1;
    end else if (update) begin
      last <= winner_in;
    end
  end

  // A tie goes to the client that was not served last.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrated controller for a shared n-bit shift-add multiplier datapath.
// Grants one of two clients, latches its operands, sequences load plus n
// add-shift/shift strobes, then captures the 2n-bit product from AQ.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned n = N_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [1:0]     req,
  input  logic [n-1:0]   a0,
  input  logic [n-1:0]   b0,
  input  logic [n-1:0]   a1,
  input  logic [n-1:0]   b1,
  input  logic           Q0,
  input  logic [2*n-1:0] AQ,
  output logic [n-1:0]   M,
  output logic [n-1:0]   Qin,
  output logic           load,
  output logic           add_shift,
  output logic           shift,
  output logic [1:0]     gnt,
  output logic [1:0]     done,
  output logic [2*n-1:0] product
);

  localparam int unsigned CW = cnt_width(n);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    arb_grant;
  logic          arb_update;
  logic          arb_winner;

  rr_arbiter2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .update    (arb_update),
    .winner_in (arb_winner),
    .grant     (arb_grant)
  );

  // Pointer moves to the client being completed.
  always_comb begin
    arb_update = (state == DONE);
    arb_winner = gnt[1];
  end

  // Main FSM with iteration counter and operand/product registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt     <= 2'b00;
      M       <= '0;
      Qin     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            M     <= arb_grant[1] ? a1 : a0;
            Qin   <= arb_grant[1] ? b1 : b0;
            gnt   <= arb_grant;
            cnt   <= CW'(n);
            state <= LOAD;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // AQ already reflects the n-th shift throughout this cycle.
          product <= AQ;
          gnt     <= 2'b00;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath strobes and completion pulse decoded from the state.
  always_comb begin
    load      = (state == LOAD);
    add_shift = (state == RUN) && Q0;
    shift     = (state == RUN) && !Q0;
    done      = (state == DONE) ? gnt : 2'b00;
  end

endmodule
